ps2_stream_ctrl: RTL and testbench

Command sequencer that drives the `start` / `send_enable` inputs of the PS/2 mouse interface. It sits between the interface and the rest of the design, which may ask for mouse streaming to be turned on or off.
- After reset it waits a power-up interval, then automatically issues the enable-streaming command (F4).
- It serialises later enable/disable requests so that a command is never issued while another is in flight.
- It can optionally re-issue F4 periodically to recover a hot-plugged mouse.

---
 rtl/ps2_stream_ctrl.sv | 109 ++++++++++
 tb/tb_ps2_stream_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_stream_ctrl.sv
// Command sequencer for the PS/2 mouse interface: auto-enables streaming after
// power-up, serialises enable/disable requests and can periodically re-issue F4.
module ps2_stream_ctrl #(
   parameter int PWRUP_CYCLES   = 25_000_000,
   parameter int CMD_CYCLES     = 100_000,
   parameter int REFRESH_CYCLES = 0
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic req_enable,
   input  logic req_disable,
   output logic start,
   output logic send_enable,
   output logic busy,
   output logic streaming,
   output logic cmd_done
);

   localparam int MAX_PC  = (PWRUP_CYCLES > CMD_CYCLES) ? PWRUP_CYCLES : CMD_CYCLES;
   localparam int MAX_PCR = (MAX_PC > REFRESH_CYCLES) ? MAX_PC : REFRESH_CYCLES;
   localparam int MAX_ALL = (MAX_PCR > 2) ? MAX_PCR : 2;
   localparam int CNT_W   = $clog2(MAX_ALL);
   localparam bit REFRESH_ON = (REFRESH_CYCLES > 0);
   localparam logic [CNT_W-1:0] PWRUP_LAST   = CNT_W'(PWRUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CMD_LAST     = CNT_W'(CMD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REFRESH_LAST = REFRESH_ON ? CNT_W'(REFRESH_CYCLES - 1) : '0;

   typedef enum logic [1:0] {S_PWRUP, S_IDLE, S_START, S_HOLD} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] ref_cnt;
   logic             cmd, cmd_nx;
   logic             pend_v, pend_cmd;
   logic             refresh_due, hold_last;

   always_comb begin
      refresh_due = REFRESH_ON && streaming && (ref_cnt == REFRESH_LAST);
      hold_last   = (state == S_HOLD) && (cnt == CMD_LAST);
      state_nx    = state;
      cmd_nx      = cmd;
      case (state)
         S_PWRUP: if (cnt == PWRUP_LAST) state_nx = S_IDLE;
         S_IDLE: begin
            if (pend_v) begin
               state_nx = S_START;
               cmd_nx   = pend_cmd;
            end else if (refresh_due) begin
               state_nx = S_START;
               cmd_nx   = 1'b1;
            end
         end
         S_START: state_nx = S_HOLD;
         S_HOLD:  if (hold_last) state_nx = S_IDLE;
         default: state_nx = S_PWRUP;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) state <= S_PWRUP;
      else       state <= state_nx;
   end

   // Counters, command latch, pending slot and completion flags
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         ref_cnt   <= '0;
         cmd       <= 1'b0;
         pend_v    <= 1'b1;
         pend_cmd  <= 1'b1;
         streaming <= 1'b0;
         cmd_done  <= 1'b0;
      end else begin
         cmd <= cmd_nx;

         case (state)
            S_PWRUP: cnt <= (cnt == PWRUP_LAST) ? '0 : cnt + 1'b1;
            S_HOLD:  cnt <= hold_last ? '0 : cnt + 1'b1;
            default: cnt <= '0;
         endcase

         // Refresh interval only runs while idle and streaming; any launch clears it.
         if (REFRESH_ON && state == S_IDLE && state_nx == S_IDLE && streaming)
            ref_cnt <= ref_cnt + 1'b1;
         else
            ref_cnt <= '0;

         // A fresh request always wins over consumption of the older one.
         if (req_disable) begin
            pend_v   <= 1'b1;
            pend_cmd <= 1'b0;
         end else if (req_enable) begin
            pend_v   <= 1'b1;
            pend_cmd <= 1'b1;
         end else if (state == S_IDLE && pend_v) begin
            pend_v <= 1'b0;
         end

         cmd_done <= hold_last;
         if (hold_last) streaming <= cmd;
      end
   end

   assign start       = (state == S_START);
   assign send_enable = cmd;
   assign busy        = (state != S_IDLE) || pend_v;

endmodule

// File: tb/tb_ps2_stream_ctrl.sv
// Bench for ps2_stream_ctrl: scoreboarded start/cmd_done events plus a
// table of single requests and hand-written multi-cycle scenarios.
module tb_ps2_stream_ctrl;

   localparam int P = 10;
   localparam int C = 5;
   localparam int R = 20;

   logic CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   logic reset, req_enable, req_disable;
   logic start, send_enable, busy, streaming, cmd_done;
   logic rstb, enb, disb;
   logic startb, seb, busyb, strb, doneb;

   ps2_stream_ctrl #(.PWRUP_CYCLES(P), .CMD_CYCLES(C), .REFRESH_CYCLES(0)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .req_enable(req_enable), .req_disable(req_disable),
      .start(start), .send_enable(send_enable), .busy(busy), .streaming(streaming),
      .cmd_done(cmd_done));

   ps2_stream_ctrl #(.PWRUP_CYCLES(P), .CMD_CYCLES(C), .REFRESH_CYCLES(R)) dut_r (
      .CLOCK_50(CLOCK_50), .reset(rstb), .req_enable(enb), .req_disable(disb),
      .start(startb), .send_enable(seb), .busy(busyb), .streaming(strb),
      .cmd_done(doneb));

   typedef struct {
      int   cyc;
      logic val;
   } ev_t;

   typedef struct {
      logic en;
      logic dis;
      logic se;
      logic st;
   } vec_t;

   ev_t  sq[$];
   ev_t  dq[$];
   ev_t  sqb[$];
   ev_t  ea, eb, ec;
   vec_t vt[6];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   cycb = 0;
   int   hold_left = 0;
   logic hold_se = 1'b0;
   int   t, t2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_s(input int c, input logic v);
      ev_t e;
      e.cyc = c; e.val = v;
      sq.push_back(e);
   endtask

   task automatic push_d(input int c, input logic v);
      ev_t e;
      e.cyc = c; e.val = v;
      dq.push_back(e);
   endtask

   task automatic push_b(input int c, input logic v);
      ev_t e;
      e.cyc = c; e.val = v;
      sqb.push_back(e);
   endtask

   always @(posedge CLOCK_50 or posedge reset)
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;

   always @(posedge CLOCK_50 or posedge rstb)
      if (rstb) cycb <= 0;
      else      cycb <= cycb + 1;

   // Scoreboard for the main instance
   always @(negedge CLOCK_50) begin
      if (reset) begin
         hold_left = 0;
      end else begin
         if (hold_left > 0) begin
            chk("send_enable_hold", send_enable, hold_se);
            hold_left--;
         end
         if (start) begin
            if (sq.size() == 0) chk("unexpected_start", cyc, -1);
            else begin
               ea = sq.pop_front();
               chk("start_cycle", cyc, ea.cyc);
               chk("start_send_enable", send_enable, ea.val);
               hold_se   = ea.val;
               hold_left = C;
            end
         end
         if (cmd_done) begin
            if (dq.size() == 0) chk("unexpected_cmd_done", cyc, -1);
            else begin
               eb = dq.pop_front();
               chk("cmd_done_cycle", cyc, eb.cyc);
               chk("cmd_done_streaming", streaming, eb.val);
            end
         end
      end
   end

   // Scoreboard for the refresh instance
   always @(negedge CLOCK_50) begin
      if (!rstb && startb) begin
         if (sqb.size() == 0) chk("refresh_unexpected_start", cycb, -1);
         else begin
            ec = sqb.pop_front();
            chk("refresh_start_cycle", cycb, ec.cyc);
            chk("refresh_send_enable", seb, ec.val);
         end
      end
   end

   task automatic wait_cyc(input int n);
      int g;
      g = 0;
      while (cyc < n && g < 2000) begin
         @(negedge CLOCK_50);
         g++;
      end
      if (cyc < n) chk("wait_cycle_timeout", cyc, n);
   endtask

   task automatic wait_cycb(input int n);
      int g;
      g = 0;
      while (cycb < n && g < 2000) begin
         @(negedge CLOCK_50);
         g++;
      end
      if (cycb < n) chk("wait_cycle_b_timeout", cycb, n);
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      @(negedge CLOCK_50);
      while (busy && g < 200) begin
         @(negedge CLOCK_50);
         g++;
      end
      if (busy) chk("idle_timeout", busy, 0);
   endtask

   task automatic drive(input logic en, input logic dis);
      req_enable  = en;
      req_disable = dis;
      @(negedge CLOCK_50);
      req_enable  = 1'b0;
      req_disable = 1'b0;
   endtask

   task automatic release_rst(input logic se0, input logic st0);
      sq.delete();
      dq.delete();
      @(negedge CLOCK_50);
      chk("rst_start", start, 0);
      chk("rst_send_enable", send_enable, 0);
      chk("rst_busy", busy, 1);
      chk("rst_streaming", streaming, 0);
      chk("rst_cmd_done", cmd_done, 0);
      push_s(P + 1, se0);
      push_d(P + C + 2, st0);
      reset = 1'b0;
   endtask

   task automatic check_powerup(input logic st0);
      wait_cyc(P + C + 1);
      chk("pwrup_busy_before_done", busy, 1);
      wait_cyc(P + C + 2);
      chk("pwrup_busy_after_done", busy, 0);
      chk("pwrup_streaming", streaming, st0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{en: 1'b0, dis: 1'b1, se: 1'b0, st: 1'b0};
      vt[1] = '{en: 1'b1, dis: 1'b0, se: 1'b1, st: 1'b1};
      vt[2] = '{en: 1'b1, dis: 1'b1, se: 1'b0, st: 1'b0};
      vt[3] = '{en: 1'b0, dis: 1'b1, se: 1'b0, st: 1'b0};
      vt[4] = '{en: 1'b1, dis: 1'b0, se: 1'b1, st: 1'b1};
      vt[5] = '{en: 1'b1, dis: 1'b0, se: 1'b1, st: 1'b1};

      reset = 1'b1; req_enable = 1'b0; req_disable = 1'b0;
      rstb  = 1'b1; enb = 1'b0; disb = 1'b0;
      repeat (3) @(negedge CLOCK_50);

      // Power-up auto-enable
      release_rst(1'b1, 1'b1);
      check_powerup(1'b1);

      // Single requests from idle
      for (int i = 0; i < 6; i++) begin
         wait_idle();
         t = cyc;
         push_s(t + 2, vt[i].se);
         push_d(t + 3 + C, vt[i].st);
         drive(vt[i].en, vt[i].dis);
         wait_cyc(t + 4 + C);
         chk("vec_streaming", streaming, vt[i].st);
         chk("vec_send_enable_kept", send_enable, vt[i].se);
         chk("vec_busy", busy, 0);
      end

      // Requests queued during HOLD: last one wins, issued right after completion
      wait_idle();
      t = cyc;
      push_s(t + 2, 1'b1);
      push_d(t + 3 + C, 1'b1);
      push_s(t + 4 + C, 1'b0);
      push_d(t + 5 + 2 * C, 1'b0);
      drive(1'b1, 1'b0);
      wait_cyc(t + 4);
      drive(1'b1, 1'b0);
      wait_cyc(t + 6);
      drive(1'b0, 1'b1);
      wait_cyc(t + 3 + C);
      chk("queued_busy_at_done", busy, 1);
      wait_cyc(t + 30);
      chk("queued_streaming", streaming, 0);
      chk("queued_busy", busy, 0);
      chk("queued_events_left", sq.size() + dq.size(), 0);

      // Disable requested during power-up replaces the auto-enable
      reset = 1'b1;
      repeat (2) @(negedge CLOCK_50);
      release_rst(1'b0, 1'b0);
      wait_cyc(3);
      drive(1'b0, 1'b1);
      check_powerup(1'b0);
      wait_cyc(40);
      chk("pwrup_req_streaming", streaming, 0);
      chk("pwrup_req_events_left", sq.size() + dq.size(), 0);

      // Reset asserted in the middle of HOLD
      wait_idle();
      t = cyc;
      push_s(t + 2, 1'b1);
      push_d(t + 3 + C, 1'b1);
      drive(1'b1, 1'b0);
      wait_idle();
      t2 = cyc;
      push_s(t2 + 2, 1'b1);
      drive(1'b1, 1'b0);
      wait_cyc(t2 + 5);
      chk("midhold_busy", busy, 1);
      chk("midhold_streaming", streaming, 1);
      chk("midhold_send_enable", send_enable, 1);
      chk("midhold_start_events_left", sq.size(), 0);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_start", start, 0);
      chk("async_rst_send_enable", send_enable, 0);
      chk("async_rst_streaming", streaming, 0);
      chk("async_rst_cmd_done", cmd_done, 0);
      chk("async_rst_busy", busy, 1);
      repeat (2) @(negedge CLOCK_50);
      release_rst(1'b1, 1'b1);
      check_powerup(1'b1);
      wait_cyc(40);
      chk("restart_events_left", sq.size() + dq.size(), 0);

      // Periodic F4 refresh, stopped by a completed disable
      push_b(11, 1'b1);
      push_b(37, 1'b1);
      push_b(63, 1'b1);
      push_b(89, 1'b1);
      push_b(96, 1'b0);
      @(negedge CLOCK_50);
      rstb = 1'b0;
      wait_cycb(92);
      chk("refresh_streaming_on", strb, 1);
      enb = 1'b0; disb = 1'b1;
      @(negedge CLOCK_50);
      disb = 1'b0;
      wait_cycb(160);
      chk("refresh_streaming_off", strb, 0);
      chk("refresh_busy", busyb, 0);
      chk("refresh_cmd_done", doneb, 0);
      chk("refresh_events_left", sqb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
